// File: rtl/pc_unit_rs.sv
// LC-3 program-counter unit: PC register, PC+1 incrementer, four-way PCMUX and a
// small circular return-address stack with sticky overflow/underflow flags.
module pc_unit_rs #(
    parameter int               WIDTH        = 16,
    parameter int               RS_DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          LD_PC,
    input  logic [1:0]                    PCMUX,
    input  logic [WIDTH-1:0]              AddrAdder_out,
    input  logic [WIDTH-1:0]              Bus_out,
    input  logic                          push_ret,
    input  logic                          clr_flags,
    output logic [WIDTH-1:0]              PC,
    output logic [WIDTH-1:0]              PC_next,
    output logic [WIDTH-1:0]              ret_top,
    output logic [$clog2(RS_DEPTH+1)-1:0] rs_count,
    output logic                          rs_empty,
    output logic                          rs_full,
    output logic                          rs_overflow,
    output logic                          rs_underflow
);
    localparam int PW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CW = $clog2(RS_DEPTH + 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] mem_q [RS_DEPTH];
    logic [WIDTH-1:0] mem_d [RS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] pc_inc;
    logic [PW-1:0]    top_idx;
    logic             empty, full, pop;

    // ptr_q names the next free slot; the top entry sits one below it.
    always_comb begin
        pc_inc  = pc_q + WIDTH'(1);
        top_idx = ptr_q - PW'(1);
        empty   = (count_q == '0);
        full    = (count_q == CW'(RS_DEPTH));
        ret_top = empty ? '0 : mem_q[top_idx];
        pop     = LD_PC && (PCMUX == 2'b11);
        case (PCMUX)
            2'b00:   PC_next = pc_inc;
            2'b01:   PC_next = AddrAdder_out;
            2'b10:   PC_next = Bus_out;
            2'b11:   PC_next = empty ? pc_q : ret_top;
            default: PC_next = pc_q;
        endcase
    end

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q && !clr_flags;
        unf_d   = unf_q && !clr_flags;
        pc_d    = LD_PC ? PC_next : pc_q;
        if (push_ret && pop && !empty) begin
            // Swap: PC takes the old top, the top slot takes the new return address.
            mem_d[top_idx] = pc_inc;
        end else begin
            if (pop) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    ptr_d   = ptr_q - PW'(1);
                    count_d = count_q - CW'(1);
                end
            end
            // A pop reaching here with a push means the stack was empty, so ptr_q is still valid.
            if (push_ret) begin
                mem_d[ptr_q] = pc_inc;
                ptr_d        = ptr_q + PW'(1);
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= RESET_VECTOR;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            mem_q <= mem_d;
        end
    end

    assign PC           = pc_q;
    assign rs_count     = count_q;
    assign rs_empty     = empty;
    assign rs_full      = full;
    assign rs_overflow  = ovf_q;
    assign rs_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_rs.sv
// Bench for pc_unit_rs: directed sequences plus random traffic, all checked against
// a queue-based model of the PC and return stack.
module tb_pc_unit_rs;
  localparam int W = 16;
  localparam int DEPTH = 4;
  localparam logic [W-1:0] RV = 16'h0000;

  logic clk;
  logic Reset, LD_PC, push_ret, clr_flags;
  logic [1:0] PCMUX;
  logic [W-1:0] AddrAdder_out, Bus_out;
  logic [W-1:0] PC, PC_next, ret_top;
  logic [2:0] rs_count;
  logic rs_empty, rs_full, rs_overflow, rs_underflow;

  int checks;
  int errors;

  // model state
  logic [W-1:0] pc_m;
  logic [W-1:0] stk_q[$];
  logic ovf_m, unf_m;
  logic [W-1:0] exp_q[$];

  pc_unit_rs #(.WIDTH(W), .RS_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .Clk(clk), .Reset(Reset), .LD_PC(LD_PC), .PCMUX(PCMUX),
    .AddrAdder_out(AddrAdder_out), .Bus_out(Bus_out),
    .push_ret(push_ret), .clr_flags(clr_flags),
    .PC(PC), .PC_next(PC_next), .ret_top(ret_top), .rs_count(rs_count),
    .rs_empty(rs_empty), .rs_full(rs_full),
    .rs_overflow(rs_overflow), .rs_underflow(rs_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [W-1:0] top;
    top = (stk_q.size() == 0) ? '0 : stk_q[stk_q.size()-1];
    check("ret_top", ret_top, top);
    check("rs_count", rs_count, stk_q.size());
    check("rs_empty", rs_empty, stk_q.size() == 0);
    check("rs_full", rs_full, stk_q.size() == DEPTH);
    check("rs_overflow", rs_overflow, ovf_m);
    check("rs_underflow", rs_underflow, unf_m);
  endtask

  // driver: apply one cycle of inputs, predict, then check after the edge
  task automatic step(input logic rst, input logic ld, input logic [1:0] mux,
                      input logic [W-1:0] aa, input logic [W-1:0] bus,
                      input logic push, input logic clr);
    logic [W-1:0] inc, npc, top;
    logic empty, pop;
    @(negedge clk);
    Reset = rst; LD_PC = ld; PCMUX = mux; AddrAdder_out = aa; Bus_out = bus;
    push_ret = push; clr_flags = clr;
    #1;
    inc = pc_m + 16'd1;
    empty = (stk_q.size() == 0);
    top = empty ? '0 : stk_q[stk_q.size()-1];
    case (mux)
      2'b00: npc = inc;
      2'b01: npc = aa;
      2'b10: npc = bus;
      default: npc = empty ? pc_m : top;
    endcase
    check("pc_next", PC_next, npc);
    pop = ld && (mux == 2'b11);
    if (rst) begin
      pc_m = RV;
      stk_q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (ld) pc_m = npc;
      if (clr) begin
        ovf_m = 1'b0;
        unf_m = 1'b0;
      end
      if (push && pop && !empty) begin
        stk_q[stk_q.size()-1] = inc;
      end else begin
        if (pop) begin
          if (empty) unf_m = 1'b1;
          else void'(stk_q.pop_back());
        end
        if (push) begin
          if (stk_q.size() == DEPTH) begin
            void'(stk_q.pop_front());
            ovf_m = 1'b1;
          end
          stk_q.push_back(inc);
        end
      end
    end
    exp_q.push_back(pc_m);
    @(posedge clk);
    #1;
    check("pc", PC, exp_q.pop_front());
    check_state();
  endtask

  task automatic load_pc(input logic [W-1:0] v);
    step(0, 1, 2'b10, '0, v, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1; LD_PC = 0; PCMUX = 0; AddrAdder_out = 0; Bus_out = 0;
    push_ret = 0; clr_flags = 0;
    pc_m = RV; ovf_m = 0; unf_m = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", PC, RV);
    check_state();

    // sequential increment from the reset vector
    for (int i = 0; i < 3; i++) step(0, 1, 2'b00, '0, '0, 0, 0);
    check("inc_seq", PC, 16'h0003);

    // call through address adder, then return
    load_pc(16'h3005);
    step(0, 1, 2'b01, 16'h4000, '0, 1, 0);
    check("call_top", ret_top, 16'h3006);
    step(0, 1, 2'b11, '0, '0, 0, 0);
    check("ret_pc", PC, 16'h3006);

    // overflow: five pushes from 0x10..0x14, then four pops and one underflow
    load_pc(16'h0010);
    for (int i = 0; i < 5; i++) step(0, 1, 2'b00, '0, '0, 1, 0);
    check("ovf_flag", rs_overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'b11, '0, '0, 0, 0);
      check("pop_val", PC, 16'h0015 - 16'(i));
    end
    step(0, 1, 2'b11, '0, '0, 0, 0);
    check("unf_hold", PC, 16'h0012);

    // swap when a push coincides with a pop
    step(0, 0, 2'b00, '0, '0, 0, 1);
    load_pc(16'h2000);
    step(0, 0, 2'b00, '0, '0, 1, 0);
    load_pc(16'h5000);
    step(0, 1, 2'b11, '0, '0, 1, 0);
    check("swap_pc", PC, 16'h2001);
    check("swap_top", ret_top, 16'h5001);
    step(0, 1, 2'b11, '0, '0, 0, 0);

    // wrap, bus load, hold
    load_pc(16'hFFFF);
    step(0, 1, 2'b00, '0, '0, 0, 0);
    check("wrap", PC, 16'h0000);
    load_pc(16'hABCD);
    step(0, 0, 2'b01, 16'h1111, 16'h2222, 0, 0);
    step(0, 0, 2'b10, 16'h3333, 16'h4444, 0, 0);
    check("hold", PC, 16'hABCD);

    // reset beats a concurrent push/load with a partly full, overflowed stack
    for (int i = 0; i < 5; i++) step(0, 0, 2'b00, '0, '0, 1, 0);
    step(0, 1, 2'b11, '0, '0, 0, 0);
    step(0, 1, 2'b11, '0, '0, 0, 0);
    step(1, 1, 2'b01, 16'h7777, '0, 1, 0);
    check("rst_pc", PC, RV);

    // underflow set wins over clear; empty push+pop
    step(0, 1, 2'b11, '0, '0, 0, 1);
    check("unf_wins", rs_underflow, 1'b1);
    step(0, 1, 2'b11, '0, '0, 1, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
